// File: rtl/cbfp_pkg.sv
// Shared widths and sample/mantissa types for the first CBFP normaliser.
package cbfp_pkg;

  localparam int CBFP_INPUT_WIDTH  = 25;
  localparam int CBFP_OUTPUT_WIDTH = 12;
  localparam int CBFP_BLOCK_SIZE   = 8;
  localparam int CBFP_LZC_WIDTH    = 5;
  localparam int NUM_STREAMS       = 4;

  typedef logic signed [CBFP_INPUT_WIDTH-1:0]  sample_t;
  typedef logic signed [CBFP_OUTPUT_WIDTH-1:0] mant_t;

endpackage

// File: rtl/cbfp_lzc.sv
// Redundant-sign-bit counter: number of bits below the MSB equal to the sign.
module cbfp_lzc
  import cbfp_pkg::*;
#(
  parameter int INPUT_WIDTH = CBFP_INPUT_WIDTH,
  parameter int LZC_WIDTH   = CBFP_LZC_WIDTH
) (
  input  logic signed [INPUT_WIDTH-1:0] din_i,
  output logic        [LZC_WIDTH-1:0]   lzc_o
);

  logic run;

  always_comb begin
    lzc_o = '0;
    run   = 1'b1;
    for (int i = INPUT_WIDTH - 2; i >= 0; i--) begin
      if (run && (din_i[i] == din_i[INPUT_WIDTH-1])) begin
        lzc_o = lzc_o + LZC_WIDTH'(1);
      end else begin
        run = 1'b0;
      end
    end
  end

endmodule

// File: rtl/cbfp1.sv
// CBFP normaliser after butterfly stage 1: per-half block exponent, shift and
// truncate 32 samples to 12-bit mantissas over a 4-stage pipeline.
module cbfp1
  import cbfp_pkg::*;
#(
  parameter int INPUT_WIDTH  = CBFP_INPUT_WIDTH,
  parameter int OUTPUT_WIDTH = CBFP_OUTPUT_WIDTH,
  parameter int BLOCK_SIZE   = CBFP_BLOCK_SIZE,
  parameter int LZC_WIDTH    = CBFP_LZC_WIDTH
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           alert_cbfp,
  input  logic signed [INPUT_WIDTH-1:0]  din_R_add_CBFP  [BLOCK_SIZE],
  input  logic signed [INPUT_WIDTH-1:0]  din_Q_add_CBFP  [BLOCK_SIZE],
  input  logic signed [INPUT_WIDTH-1:0]  din_R_sub_CBFP  [BLOCK_SIZE],
  input  logic signed [INPUT_WIDTH-1:0]  din_Q_sub_CBFP  [BLOCK_SIZE],
  output logic signed [OUTPUT_WIDTH-1:0] dout_R_add_CBFP [BLOCK_SIZE],
  output logic signed [OUTPUT_WIDTH-1:0] dout_Q_add_CBFP [BLOCK_SIZE],
  output logic signed [OUTPUT_WIDTH-1:0] dout_R_sub_CBFP [BLOCK_SIZE],
  output logic signed [OUTPUT_WIDTH-1:0] dout_Q_sub_CBFP [BLOCK_SIZE],
  output logic                           valid_mod1
);

  // Flattened lane order: R_add, Q_add, R_sub, Q_sub; lower half is the add path.
  localparam int NL   = NUM_STREAMS * BLOCK_SIZE;
  localparam int HALF = NL / 2;

  function automatic logic signed [INPUT_WIDTH-1:0] norm_shift(
    input logic signed [INPUT_WIDTH-1:0] x,
    input logic        [LZC_WIDTH-1:0]   e
  );
    return x <<< e;
  endfunction

  function automatic logic signed [OUTPUT_WIDTH-1:0] trunc_mant(
    input logic signed [INPUT_WIDTH-1:0] x
  );
    return x[INPUT_WIDTH-1 -: OUTPUT_WIDTH];
  endfunction

  logic signed [INPUT_WIDTH-1:0]  smp_in      [NL];
  logic signed [INPUT_WIDTH-1:0]  smp_p0_d    [NL];
  logic signed [INPUT_WIDTH-1:0]  smp_p0_q    [NL];
  logic                           vld_p0_q;
  logic signed [INPUT_WIDTH-1:0]  smp_p1_q    [NL];
  logic        [LZC_WIDTH-1:0]    lzc_p1_d    [NL];
  logic        [LZC_WIDTH-1:0]    lzc_p1_q    [NL];
  logic                           vld_p1_q;
  logic signed [INPUT_WIDTH-1:0]  smp_p2_q    [NL];
  logic        [LZC_WIDTH-1:0]    exp_add_p2_d, exp_add_p2_q;
  logic        [LZC_WIDTH-1:0]    exp_sub_p2_d, exp_sub_p2_q;
  logic                           vld_p2_q;
  logic signed [OUTPUT_WIDTH-1:0] dout_p3_d   [NL];
  logic signed [OUTPUT_WIDTH-1:0] dout_p3_q   [NL];
  logic                           vld_p3_q;

  always_comb begin
    for (int l = 0; l < BLOCK_SIZE; l++) begin
      smp_in[l]                = din_R_add_CBFP[l];
      smp_in[BLOCK_SIZE+l]     = din_Q_add_CBFP[l];
      smp_in[2*BLOCK_SIZE+l]   = din_R_sub_CBFP[l];
      smp_in[3*BLOCK_SIZE+l]   = din_Q_sub_CBFP[l];
    end
  end

  // Stage 1 capture: data held between strobes
  always_comb begin
    for (int i = 0; i < NL; i++) begin
      smp_p0_d[i] = alert_cbfp ? smp_in[i] : smp_p0_q[i];
    end
  end

  // Stage 2: per-sample redundant sign bits
  for (genvar g = 0; g < NL; g++) begin : g_lzc
    cbfp_lzc #(
      .INPUT_WIDTH (INPUT_WIDTH),
      .LZC_WIDTH   (LZC_WIDTH)
    ) u_lzc (
      .din_i (smp_p0_q[g]),
      .lzc_o (lzc_p1_d[g])
    );
  end

  // Stage 3: block exponent is the smallest count in each half
  always_comb begin
    exp_add_p2_d = LZC_WIDTH'(INPUT_WIDTH - 1);
    exp_sub_p2_d = LZC_WIDTH'(INPUT_WIDTH - 1);
    for (int i = 0; i < HALF; i++) begin
      if (lzc_p1_q[i] < exp_add_p2_d) exp_add_p2_d = lzc_p1_q[i];
      if (lzc_p1_q[HALF+i] < exp_sub_p2_d) exp_sub_p2_d = lzc_p1_q[HALF+i];
    end
  end

  // Stage 4: shift by half exponent and truncate; outputs hold between blocks
  always_comb begin
    for (int i = 0; i < NL; i++) begin
      dout_p3_d[i] = dout_p3_q[i];
      if (vld_p2_q) begin
        dout_p3_d[i] = trunc_mant(norm_shift(smp_p2_q[i],
                                             (i < HALF) ? exp_add_p2_q : exp_sub_p2_q));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_p0_q     <= 1'b0;
      vld_p1_q     <= 1'b0;
      vld_p2_q     <= 1'b0;
      vld_p3_q     <= 1'b0;
      exp_add_p2_q <= '0;
      exp_sub_p2_q <= '0;
      for (int i = 0; i < NL; i++) begin
        smp_p0_q[i]  <= '0;
        smp_p1_q[i]  <= '0;
        lzc_p1_q[i]  <= '0;
        smp_p2_q[i]  <= '0;
        dout_p3_q[i] <= '0;
      end
    end else begin
      vld_p0_q     <= alert_cbfp;
      vld_p1_q     <= vld_p0_q;
      vld_p2_q     <= vld_p1_q;
      vld_p3_q     <= vld_p2_q;
      exp_add_p2_q <= exp_add_p2_d;
      exp_sub_p2_q <= exp_sub_p2_d;
      for (int i = 0; i < NL; i++) begin
        smp_p0_q[i]  <= smp_p0_d[i];
        smp_p1_q[i]  <= smp_p0_q[i];
        lzc_p1_q[i]  <= lzc_p1_d[i];
        smp_p2_q[i]  <= smp_p1_q[i];
        dout_p3_q[i] <= dout_p3_d[i];
      end
    end
  end

  always_comb begin
    for (int l = 0; l < BLOCK_SIZE; l++) begin
      dout_R_add_CBFP[l] = dout_p3_q[l];
      dout_Q_add_CBFP[l] = dout_p3_q[BLOCK_SIZE+l];
      dout_R_sub_CBFP[l] = dout_p3_q[2*BLOCK_SIZE+l];
      dout_Q_sub_CBFP[l] = dout_p3_q[3*BLOCK_SIZE+l];
    end
  end

  assign valid_mod1 = vld_p3_q;

endmodule

// File: tb/tb_cbfp1.sv
// Bench for cbfp1: directed blocks plus random blocks against an arithmetic
// reference (bit-length exponent, multiply-and-floor mantissa, latency queue).
module tb_cbfp1;
  import cbfp_pkg::*;

  logic    clk = 1'b0;
  logic    rstn = 1'b0;
  logic    alert = 1'b0;
  sample_t r_add [8], q_add [8], r_sub [8], q_sub [8];
  mant_t   or_add[8], oq_add[8], or_sub[8], oq_sub[8];
  logic    valid;

  cbfp1 dut (
    .clk             (clk),
    .rstn            (rstn),
    .alert_cbfp      (alert),
    .din_R_add_CBFP  (r_add),
    .din_Q_add_CBFP  (q_add),
    .din_R_sub_CBFP  (r_sub),
    .din_Q_sub_CBFP  (q_sub),
    .dout_R_add_CBFP (or_add),
    .dout_Q_add_CBFP (oq_add),
    .dout_R_sub_CBFP (or_sub),
    .dout_Q_sub_CBFP (oq_sub),
    .valid_mod1      (valid)
  );

  always #5 clk = ~clk;

  int samp [32];
  int held [32];
  int rpipe[3][32];
  bit vpipe[3];
  bit exp_valid;
  int n_vec = 0;
  int n_err = 0;
  int n_pulse = 0;

  // Exponent = 24 minus the magnitude bit length of x (or of ~x when negative).
  function automatic int lzc_ref(input int x);
    int v = (x < 0) ? ~x : x;
    int n = 0;
    while (v != 0) begin
      v = v >> 1;
      n++;
    end
    return 24 - n;
  endfunction

  // Mantissa = floor(x * 2^e / 2^13).
  function automatic int mant_ref(input int x, input int e);
    longint p = longint'(x) * (longint'(1) << e);
    return int'(p >>> 13);
  endfunction

  function automatic int rnd_sample(input int k);
    int v = $urandom;
    return v >>> k;
  endfunction

  function automatic int dut_out(input int i);
    int l = i % 8;
    case (i / 8)
      0:       return int'(or_add[l]);
      1:       return int'(oq_add[l]);
      2:       return int'(or_sub[l]);
      default: return int'(oq_sub[l]);
    endcase
  endfunction

  task automatic drive();
    for (int l = 0; l < 8; l++) begin
      r_add[l] = samp[l][24:0];
      q_add[l] = samp[8+l][24:0];
      r_sub[l] = samp[16+l][24:0];
      q_sub[l] = samp[24+l][24:0];
    end
  endtask

  task automatic model_edge();
    int ea, es;
    if (!rstn) begin
      for (int s = 0; s < 3; s++) vpipe[s] = 1'b0;
      for (int i = 0; i < 32; i++) held[i] = 0;
      exp_valid = 1'b0;
    end else begin
      exp_valid = vpipe[2];
      if (vpipe[2]) for (int i = 0; i < 32; i++) held[i] = rpipe[2][i];
      for (int i = 0; i < 32; i++) begin
        rpipe[2][i] = rpipe[1][i];
        rpipe[1][i] = rpipe[0][i];
      end
      vpipe[2] = vpipe[1];
      vpipe[1] = vpipe[0];
      vpipe[0] = alert;
      if (alert) begin
        ea = 24;
        es = 24;
        for (int i = 0; i < 16; i++) begin
          if (lzc_ref(samp[i]) < ea) ea = lzc_ref(samp[i]);
          if (lzc_ref(samp[16+i]) < es) es = lzc_ref(samp[16+i]);
        end
        for (int i = 0; i < 32; i++) rpipe[0][i] = mant_ref(samp[i], (i < 16) ? ea : es);
      end
    end
  endtask

  task automatic check(input string tag);
    int obs;
    n_vec++;
    assert (valid === exp_valid) else begin
      n_err++;
      $error("FAIL %s valid obs=%0b exp=%0b", tag, valid, exp_valid);
    end
    if (valid === 1'b1) n_pulse++;
    for (int i = 0; i < 32; i++) begin
      obs = dut_out(i);
      n_vec++;
      assert (obs === held[i]) else begin
        n_err++;
        $error("FAIL %s lane%0d obs=%0d exp=%0d", tag, i, obs, held[i]);
      end
    end
  endtask

  task automatic expect_lane(input string tag, input int i, input int val);
    int obs = dut_out(i);
    n_vec++;
    assert (obs === val) else begin
      n_err++;
      $error("FAIL %s lane%0d obs=%0d exp=%0d", tag, i, obs, val);
    end
  endtask

  task automatic tick(input string tag);
    drive();
    model_edge();
    @(posedge clk);
    #1;
    check(tag);
  endtask

  task automatic strobe_and_drain(input string tag);
    alert = 1'b1;
    tick(tag);
    alert = 1'b0;
    for (int c = 0; c < 4; c++) tick(tag);
  endtask

  initial begin
    int pulses_before;
    for (int i = 0; i < 32; i++) samp[i] = 0;
    rstn = 1'b0;
    alert = 1'b1;
    tick("reset");
    tick("reset");
    rstn = 1'b1;
    alert = 1'b0;
    tick("idle");

    // add half: R=4096, Q=0 -> e_add=11
    for (int i = 0; i < 32; i++) samp[i] = (i < 8) ? 4096 : 0;
    strobe_and_drain("addhalf");
    for (int i = 0; i < 16; i++) expect_lane("addhalf_c", i, (i < 8) ? 1024 : 0);

    // full scale
    for (int i = 0; i < 32; i++) samp[i] = 0;
    samp[0] = 16777215;
    samp[1] = -16777216;
    strobe_and_drain("fullscale");
    expect_lane("fullscale_c", 0, 2047);
    expect_lane("fullscale_c", 1, -2048);
    expect_lane("fullscale_c", 2, 0);

    // mixed: -4096 with 100s -> e_add=12
    for (int i = 0; i < 16; i++) samp[i] = 100;
    samp[0] = -4096;
    strobe_and_drain("mixed");
    expect_lane("mixed_c", 0, -2048);
    expect_lane("mixed_c", 5, 50);
    expect_lane("mixed_c", 12, 50);

    // independent halves
    for (int i = 0; i < 32; i++) samp[i] = (i < 16) ? 4096 : ((i < 24) ? 1 : 0);
    strobe_and_drain("halves");
    expect_lane("halves_c", 9, 1024);
    expect_lane("halves_c", 17, 1024);
    expect_lane("halves_c", 27, 0);

    // back-to-back strobes
    for (int i = 0; i < 32; i++) samp[i] = 4096;
    alert = 1'b1;
    tick("b2b");
    for (int i = 0; i < 32; i++) samp[i] = 1;
    tick("b2b");
    for (int i = 0; i < 32; i++) samp[i] = 0;
    alert = 1'b0;
    pulses_before = n_pulse;
    for (int c = 0; c < 5; c++) tick("b2b");
    n_vec++;
    assert (n_pulse - pulses_before === 2) else begin
      n_err++;
      $error("FAIL b2b_pulses obs=%0d exp=2", n_pulse - pulses_before);
    end
    expect_lane("b2b_hold", 31, 1024);

    // reset one cycle after a strobe flushes the block
    for (int i = 0; i < 32; i++) samp[i] = rnd_sample(9);
    alert = 1'b1;
    tick("rstflush");
    alert = 1'b0;
    rstn = 1'b0;
    tick("rstflush");
    rstn = 1'b1;
    pulses_before = n_pulse;
    for (int c = 0; c < 5; c++) tick("rstflush");
    n_vec++;
    assert (n_pulse === pulses_before) else begin
      n_err++;
      $error("FAIL rstflush_pulses obs=%0d exp=0", n_pulse - pulses_before);
    end
    expect_lane("rstflush_c", 0, 0);

    // 32 sequential random blocks
    pulses_before = n_pulse;
    alert = 1'b1;
    for (int b = 0; b < 32; b++) begin
      int ka = $urandom_range(7, 31);
      int ks = $urandom_range(7, 31);
      for (int i = 0; i < 32; i++) samp[i] = rnd_sample((i < 16) ? ka : ks);
      tick("seq");
    end
    alert = 1'b0;
    for (int c = 0; c < 4; c++) tick("seq");
    n_vec++;
    assert (n_pulse - pulses_before === 32) else begin
      n_err++;
      $error("FAIL seq_pulses obs=%0d exp=32", n_pulse - pulses_before);
    end

    // random gaps
    for (int c = 0; c < 60; c++) begin
      int ka = $urandom_range(7, 31);
      int ks = $urandom_range(7, 31);
      alert = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < 32; i++) samp[i] = rnd_sample((i < 16) ? ka : ks);
      tick("gaps");
    end
    alert = 1'b0;
    for (int c = 0; c < 4; c++) tick("gaps");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
